// File: rtl/tl_pkg.sv
// ============================================================================
// Module   : tl_pkg
// Brief    : Light codes, phase/traffic-light state encodings, phase decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package tl_pkg;

  localparam logic [1:0] LIGHT_GREEN  = 2'b00;
  localparam logic [1:0] LIGHT_RED    = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    FAULT  = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    TL_NS_GREEN  = 2'd0,
    TL_NS_YELLOW = 2'd1,
    TL_EW_GREEN  = 2'd2,
    TL_EW_YELLOW = 2'd3
  } tl_state_t;

  function automatic phase_t decode_phase(input logic [1:0] es, input logic [1:0] ns);
    phase_t result;
    result = FAULT;
    if ((es == LIGHT_GREEN && ns == LIGHT_RED) || (es == LIGHT_RED && ns == LIGHT_GREEN))
      result = GREEN;
    else if ((es == LIGHT_YELLOW && ns == LIGHT_RED) || (es == LIGHT_RED && ns == LIGHT_YELLOW))
      result = YELLOW;
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sec_prescaler.sv
// ============================================================================
// Module   : sec_prescaler
// Brief    : Wrapping 0..CLK_PER_SEC-1 counter producing a one-second tick.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sec_prescaler #(
  parameter int CLK_PER_SEC = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic hold,
  output logic sec_tick
);

  localparam int c_WIDTH = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [c_WIDTH-1:0] c_MAX = c_WIDTH'(CLK_PER_SEC - 1);

  logic [c_WIDTH-1:0] r_count;

  // Clear wins over hold so a phase change always restarts the second.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_count <= '0;
    else if (clear)
      r_count <= '0;
    else if (!hold)
      r_count <= (r_count == c_MAX) ? '0 : r_count + c_WIDTH'(1);
  end

  assign sec_tick = (r_count == c_MAX);

endmodule

`default_nettype wire

// File: rtl/light_phase_timer.sv
// ============================================================================
// Module   : light_phase_timer
// Brief    : Times green/yellow phases of a light pair; optional hold input
//            enabled by macro PHASE_HOLD_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module light_phase_timer
  import tl_pkg::*;
#(
  parameter int CLK_PER_SEC = 50000000,
  parameter int GREEN_SEC   = 10,
  parameter int YELLOW_SEC  = 2
) (
  input  logic       clk,
  input  logic       rst,
`ifdef PHASE_HOLD_EN
  input  logic       hold,
`endif
  input  logic [1:0] es_light,
  input  logic [1:0] ns_light,
  output logic       count_10,
  output logic       count_2,
  output logic [3:0] sec_cnt,
  output logic       phase_err
);

  phase_t     r_state;
  phase_t     w_next_state;
  phase_t     w_phase;
  logic       w_change;
  logic       w_active;
  logic       w_clear;
  logic       w_hold;
  logic       w_tick;
  logic       w_count;
  logic       w_at_limit;
  logic [3:0] w_limit;
  logic [3:0] r_sec_cnt;
  logic       r_count_10;
  logic       r_count_2;
  logic       r_phase_err;

`ifdef PHASE_HOLD_EN
  assign w_hold = hold;
`else
  assign w_hold = 1'b0;
`endif

  sec_prescaler #(
    .CLK_PER_SEC (CLK_PER_SEC)
  ) u_sec_prescaler (
    .clk      (clk),
    .rst      (rst),
    .clear    (w_clear),
    .hold     (w_hold),
    .sec_tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= IDLE;
    else
      r_state <= w_next_state;
  end

  // Counting only happens in a stable timed phase; a tick on a phase-change edge is discarded.
  always_comb begin
    w_phase      = decode_phase(es_light, ns_light);
    w_next_state = w_phase;
    w_change     = (w_phase != r_state);
    w_active     = (r_state == GREEN) || (r_state == YELLOW);
    w_clear      = w_change || !w_active;
    w_count      = w_tick && !w_clear && !w_hold;
    w_limit      = (r_state == GREEN) ? 4'(GREEN_SEC - 1) : 4'(YELLOW_SEC - 1);
    w_at_limit   = w_count && (r_sec_cnt == w_limit);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sec_cnt   <= 4'd0;
      r_count_10  <= 1'b0;
      r_count_2   <= 1'b0;
      r_phase_err <= 1'b0;
    end else begin
      if (w_clear || w_at_limit)
        r_sec_cnt <= 4'd0;
      else if (w_count)
        r_sec_cnt <= r_sec_cnt + 4'd1;
      r_count_10  <= w_at_limit && (r_state == GREEN);
      r_count_2   <= w_at_limit && (r_state == YELLOW);
      r_phase_err <= (w_phase == FAULT);
    end
  end

  assign count_10  = r_count_10;
  assign count_2   = r_count_2;
  assign sec_cnt   = r_sec_cnt;
  assign phase_err = r_phase_err;

endmodule

`default_nettype wire

// File: tb/tb_light_phase_timer.sv
// ============================================================================
// Module   : tb_light_phase_timer
// Brief    : Self-checking bench for light_phase_timer (CLK_PER_SEC=4); the
//            hold scenario runs when PHASE_HOLD_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_light_phase_timer;
  import tl_pkg::*;

  localparam int CPS = 4;
  localparam int GS  = 10;
  localparam int YS  = 2;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       hold = 1'b0;
  logic [1:0] es_light = 2'b11;
  logic [1:0] ns_light = 2'b11;
  logic       count_10, count_2, phase_err;
  logic [3:0] sec_cnt;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk   = 0;

  light_phase_timer #(
    .CLK_PER_SEC (CPS),
    .GREEN_SEC   (GS),
    .YELLOW_SEC  (YS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef PHASE_HOLD_EN
    .hold      (hold),
`endif
    .es_light  (es_light),
    .ns_light  (ns_light),
    .count_10  (count_10),
    .count_2   (count_2),
    .sec_cnt   (sec_cnt),
    .phase_err (phase_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 1 = green, 2 = yellow, 3 = fault
  function automatic int ph(input logic [1:0] es, input logic [1:0] ns);
    int r;
    case ({es, ns})
      4'b0001, 4'b0100: r = 1;
      4'b1001, 4'b0110: r = 2;
      default:          r = 3;
    endcase
    return r;
  endfunction

  // Model: e = counted edges since phase entry; pulse when e hits a multiple of the period.
  int         m_phase = 0;
  int         m_e     = 0;
  int         p_now, e_nxt;
  bit         cnt_nxt;
  logic       exp_c10 = 1'b0, exp_c2 = 1'b0, exp_err = 1'b0;
  logic [3:0] exp_sec = 4'd0;

  always_comb begin
    p_now   = ph(es_light, ns_light);
    cnt_nxt = 1'b0;
    e_nxt   = 0;
    if (p_now == m_phase && p_now != 3) begin
      if (hold) e_nxt = m_e;
      else begin
        e_nxt   = m_e + 1;
        cnt_nxt = 1'b1;
      end
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase <= 0;
      m_e     <= 0;
      exp_c10 <= 1'b0;
      exp_c2  <= 1'b0;
      exp_sec <= 4'd0;
      exp_err <= 1'b0;
    end else begin
      m_phase <= p_now;
      m_e     <= e_nxt;
      exp_err <= (p_now == 3);
      exp_c10 <= cnt_nxt && p_now == 1 && (e_nxt % (GS * CPS)) == 0;
      exp_c2  <= cnt_nxt && p_now == 2 && (e_nxt % (YS * CPS)) == 0;
      exp_sec <= (p_now == 3) ? 4'd0 : 4'((e_nxt / CPS) % ((p_now == 1) ? GS : YS));
    end
  end

  task automatic chk1(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      chk1("count_10", int'(count_10), int'(exp_c10));
      chk1("count_2", int'(count_2), int'(exp_c2));
      chk1("sec_cnt", int'(sec_cnt), int'(exp_sec));
      chk1("phase_err", int'(phase_err), int'(exp_err));
      chk1("pulse_excl", int'(count_10 & count_2), 0);
    end
  end

  task automatic set_lights(input logic [1:0] es, input logic [1:0] ns);
    es_light = es;
    ns_light = ns;
  endtask

  task automatic wait_pulse(input bit is10, input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if ((is10 ? count_10 : count_2) === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL pulse_timeout: got no pulse, expected one within %0d cycles", bound);
    end
  endtask

  task automatic apply_tl(input tl_state_t s);
    case (s)
      TL_NS_GREEN:  set_lights(LIGHT_RED, LIGHT_GREEN);
      TL_NS_YELLOW: set_lights(LIGHT_RED, LIGHT_YELLOW);
      TL_EW_GREEN:  set_lights(LIGHT_GREEN, LIGHT_RED);
      default:      set_lights(LIGHT_YELLOW, LIGHT_RED);
    endcase
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected end before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int mark, at, total, found;
    tl_state_t tl;

    // Reset, then green timing
    #2 rst = 1'b0;
    set_lights(LIGHT_GREEN, LIGHT_RED);
    repeat (3) @(negedge clk);
    chk = 1;
    chk1("reset_sec", int'(sec_cnt), 0);
    chk1("reset_err", int'(phase_err), 0);
    rst  = 1'b1;
    mark = cyc;
    @(negedge clk);
    chk1("green_entry_sec", int'(sec_cnt), 0);
    chk1("green_entry_err", int'(phase_err), 0);
    wait_pulse(1'b1, 60, at);
    chk1("green_latency", at - mark - 1, 40);
    @(negedge clk);
    chk1("green_width", int'(count_10), 0);

    // Yellow timing and auto-repeat, including an orientation swap inside yellow
    set_lights(LIGHT_RED, LIGHT_YELLOW);
    mark = cyc;
    wait_pulse(1'b0, 20, at);
    chk1("yellow_latency", at - mark - 1, 8);
    mark = at;
    wait_pulse(1'b0, 20, at);
    chk1("yellow_repeat", at - mark, 8);
    mark = at;
    repeat (3) @(negedge clk);
    set_lights(LIGHT_YELLOW, LIGHT_RED);
    wait_pulse(1'b0, 20, at);
    chk1("yellow_swap_repeat", at - mark, 8);

    // Fault mid-green
    set_lights(LIGHT_GREEN, LIGHT_RED);
    repeat (20) @(negedge clk);
    set_lights(2'b11, LIGHT_RED);
    repeat (3) @(negedge clk);
    chk1("fault_err", int'(phase_err), 1);
    chk1("fault_sec", int'(sec_cnt), 0);
    set_lights(LIGHT_GREEN, LIGHT_GREEN);
    @(negedge clk);
    chk1("fault_both_green_err", int'(phase_err), 1);
    set_lights(LIGHT_RED, LIGHT_GREEN);
    mark = cyc;
    @(negedge clk);
    chk1("fault_clear_err", int'(phase_err), 0);
    wait_pulse(1'b1, 60, at);
    chk1("fault_recover_latency", at - mark - 1, 40);

    // Reset mid-phase at sec_cnt == 7
    found = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (sec_cnt == 4'd7) begin
        found = 1;
        break;
      end
    end
    chk1("reach_sec7", found, 1);
    #2 rst = 1'b0;
    #1;
    chk1("async_rst_c10", int'(count_10), 0);
    chk1("async_rst_c2", int'(count_2), 0);
    chk1("async_rst_sec", int'(sec_cnt), 0);
    chk1("async_rst_err", int'(phase_err), 0);
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b1;
    mark = cyc;
    wait_pulse(1'b1, 60, at);
    chk1("rst_mid_latency", at - mark - 1, 40);

`ifdef PHASE_HOLD_EN
    // Hold for 12 edges during green delays the repeat pulse by 12
    mark = at;
    repeat (10) @(negedge clk);
    hold = 1'b1;
    repeat (12) @(negedge clk);
    hold = 1'b0;
    wait_pulse(1'b1, 80, at);
    chk1("hold_delay", at - mark, 52);
`endif

    // Closed loop with a traffic-light sequencer reacting to the pulses
    set_lights(2'b11, 2'b11);
    @(negedge clk);
    tl = TL_NS_GREEN;
    apply_tl(tl);
    mark  = cyc;
    total = 0;
    for (int k = 0; k < 4; k++) begin
      wait_pulse((k % 2) == 0, 60, at);
      total += at - mark - 1;
      chk1("loop_phase", ph(es_light, ns_light), ((k % 2) == 0) ? 1 : 2);
      case (tl)
        TL_NS_GREEN:  tl = TL_NS_YELLOW;
        TL_NS_YELLOW: tl = TL_EW_GREEN;
        TL_EW_GREEN:  tl = TL_EW_YELLOW;
        default:      tl = TL_NS_GREEN;
      endcase
      apply_tl(tl);
      mark = cyc;
    end
    chk1("loop_total", total, 96);

    @(negedge clk);
    chk = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/light_phase_timer.md
LIGHT_PHASE_TIMER -- requirements
Module: light_phase_timer

Interface
REQ-001 Parameter CLK_PER_SEC, default 50000000: clk cycles per one-second tick; legal range is 2 or more.
REQ-002 Parameter GREEN_SEC, default 10: seconds a green phase lasts before count_10 pulses; legal range is 1 to 15.
REQ-003 Parameter YELLOW_SEC, default 2: seconds a yellow phase lasts before count_2 pulses; legal range is 1 to 15.
REQ-004 clk  in  1  single system clock; all state is updated on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 es_light  in  2  east-west light from the downstream controller (00 green, 01 red, 10 yellow, 11 invalid).
REQ-007 ns_light  in  2  north-south light, encoded the same way as es_light.
REQ-008 count_10  out  1  one-cycle registered pulse: green phase time has expired.
REQ-009 count_2  out  1  one-cycle registered pulse: yellow phase time has expired.
REQ-010 sec_cnt  out  4  whole seconds elapsed in the current phase.
REQ-011 phase_err  out  1  registered flag: the light pair is not a legal phase.

Function
REQ-012 The block SHALL decode the phase combinationally as follows:
- GREEN: one light is 00 and the other is 01.
- YELLOW: one light is 10 and the other is 01.
- FAULT: any other combination.
REQ-013 The FSM SHALL have states IDLE, GREEN, YELLOW and FAULT; each edge loads the decoded phase, and IDLE is occupied only after reset.
REQ-014 Prescaler: counts 0..CLK_PER_SEC-1 and wraps; sec_tick is high during the cycle the prescaler equals CLK_PER_SEC-1.
REQ-015 sec_cnt SHALL increment on each edge where sec_tick is high, while in GREEN or YELLOW.
REQ-016 In GREEN, on the edge where sec_tick is high and sec_cnt equals GREEN_SEC-1:
- count_10 SHALL be 1 for exactly the next cycle;
- sec_cnt SHALL load 0 on that same edge.
REQ-017 The YELLOW_SEC / count_2 case SHALL behave identically to REQ-016.
REQ-018 If the phase stays unchanged after a pulse, counting SHALL restart and the pulse SHALL repeat each period (auto-repeat).
REQ-019 On any edge where the decoded phase differs from the FSM state:
- prescaler and sec_cnt SHALL clear to 0;
- no pulse SHALL be generated on that edge, even if a tick coincides.
REQ-020 In FAULT:
- phase_err=1;
- counters held at 0;
- count_10 and count_2 held at 0.
REQ-021 phase_err SHALL clear on the first edge with a legal phase.
REQ-022 count_10 and count_2 SHALL never be high in the same cycle.

Reset
REQ-023 With rst=0, the block SHALL immediately (asynchronously) set:
- FSM=IDLE;
- prescaler=0;
- sec_cnt=0;
- count_10=0, count_2=0, phase_err=0.
REQ-024 On the first edge after rst releases, the FSM SHALL load the decoded phase, with counting starting from 0.
REQ-025 Reset asserted mid-phase SHALL abort any pending pulse; no pulse SHALL appear after release until a full phase period has elapsed.

Configuration
REQ-026 Macro PHASE_HOLD_EN SHALL control a hold input (1 bit):
- Defined: hold=1 freezes prescaler, sec_cnt and the pulse outputs (both pulses 0); phase-change clearing still applies; counting resumes from the frozen values when hold=0.
- Undefined: the hold port is absent and counting is never frozen.

Structure
REQ-027 Shared package tl_pkg SHALL hold:
- light codes LIGHT_GREEN=00, LIGHT_RED=01, LIGHT_YELLOW=10;
- the phase state enum (IDLE, GREEN, YELLOW, FAULT);
- the traffic_light state encodings.
REQ-028 Sub-module sec_prescaler SHALL contain the prescaler: parameter CLK_PER_SEC; ports clk, rst, clear, hold, sec_tick.
REQ-029 The prescaler width SHALL be $clog2(CLK_PER_SEC).

Verification
REQ-030 The bench SHALL cover the following scenarios, all with CLK_PER_SEC=4:
- Green timing: es=00, ns=01 after reset release -> count_10 high for exactly one cycle, 40 cycles after the first edge; sec_cnt counts 0..9.
- Yellow timing: es=01, ns=10 -> count_2 high for one cycle, 8 cycles after phase entry; repeats every 8 cycles while the phase is held.
- Closed loop with traffic_light: full cycle takes 10+2+10+2 s = 96 cycles; lights follow GREEN -> YELLOW -> GREEN -> YELLOW.
- Fault: es=11 for 3 cycles mid-green -> phase_err=1 and sec_cnt=0; return to green -> phase_err=0 and a full 40-cycle wait before count_10.
- Reset mid-phase: rst low for 2 cycles at sec_cnt=7 -> all outputs 0 asynchronously; after release, count_10 arrives 40 cycles later.
- PHASE_HOLD_EN defined: hold=1 for 12 cycles during green -> count_10 delayed by exactly 12 cycles.
